aes_decrypt_feeder: RTL and testbench
=====================================

Name: aes_decrypt_feeder

Overview:
Word-stream front end and back end for the AES-256 decrypt core. It packs four 32-bit ciphertext words into one 128-bit block and waits for the expanded key schedule to be valid. It then issues a one-cycle start pulse to the decrypt core, captures the plaintext when the core signals completion, and streams the result back out as four 32-bit words. It sits between the chip's word bus (sensor/host interface) and the decrypt core; the key expander's valid feeds it directly.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in BUSY before the block is abandoned and err is set (range 2..1023)
CNT_W, 16, width of blocks_done counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 resets on the clock edge)
in_word  input  32  ciphertext word
in_valid  input  1  in_word valid
in_ready  output  1  feeder accepts in_word this cycle
key_valid  input  1  key schedule expanded and stable
dec_data_in  output  128  ciphertext block to decrypt core
dec_ready  output  1  one-cycle start pulse to decrypt core
dec_data_out  input  128  plaintext from decrypt core
dec_valid  input  1  decrypt core result valid (level)
out_word  output  32  plaintext word
out_valid  output  1  out_word valid
out_ready  input  1  consumer accepts out_word
err  output  1  sticky timeout flag
err_clr  input  1  clears err
blocks_done  output  CNT_W  completed-block count, wraps

Behaviour:
- Reset (rst==0 at edge): state FILL, word index 0, dec_data_in=0, dec_ready=0, in_ready=0 during the reset cycle, out_valid=0, out_word=0, err=0, blocks_done=0, busy counter 0, dec_valid_q=1. Reset mid-operation abandons any block silently.
- States: FILL -> WAIT_KEY -> START -> BUSY -> DRAIN -> FILL.
- FILL: in_ready=1.
  - Transfer on in_valid&in_ready.
  - Word k (k=0..3) lands in dec_data_in[127-32k -: 32]; first word is MSW.
  - After the 4th transfer go to WAIT_KEY.
  - in_ready=0 in all other states.
- WAIT_KEY: when key_valid==1 go to START. If key_valid is already 1 at entry, this costs one cycle.
- START: dec_ready=1 for exactly this cycle, then BUSY with busy counter cleared. dec_data_in is held stable from the end of FILL through the end of BUSY.
- BUSY:
  - dec_valid_q registers dec_valid every cycle.
  - Capture occurs only on the rising edge (dec_valid & ~dec_valid_q). A level held high from a previous block is ignored.
  - On capture: latch dec_data_out into the output buffer, blocks_done += 1 (mod 2^CNT_W), go to DRAIN.
  - Busy counter increments every cycle. If it reaches TIMEOUT_CYCLES-1 without capture: err<=1, discard the block, go to FILL.
  - If capture and timeout occur in the same cycle, capture wins.
- DRAIN:
  - out_valid=1; out_word = buffer[127-32k -: 32] for word index k.
  - Transfer on out_valid&out_ready.
  - After the 4th transfer: out_valid=0, go to FILL.
  - Backpressure may hold out_word for any number of cycles; it must stay stable while stalled.
- err: set by timeout, cleared by err_clr. Set wins if both occur in the same cycle. Sticky otherwise; it does not block operation.
- key_valid dropping in BUSY/DRAIN is ignored. It only gates the WAIT_KEY->START transition.
- Minimum latency: last input word accepted at cycle N; dec_ready at N+2 (key ready); first out_word valid one cycle after capture.

Test Plan:
1. key_valid=1; send a5242211, 7500d3e8, 2c96d0da, fc491931 (core model returns 1212121234343434ababababcdcdcdcd 16 cycles after dec_ready) -> dec_data_in=a52422117500d3e82c96d0dafc491931, exactly one dec_ready pulse; out words 12121212, 34343434, abababab, cdcdcdcd in order; blocks_done=1, err=0.
2. key_valid=0 while filling, raised 30 cycles after the 4th word -> no dec_ready until the cycle after key_valid rises; same output as test 1.
3. Core model never raises dec_valid, TIMEOUT_CYCLES=64 -> err=1 at BUSY cycle 63; no out_valid; returns to FILL with in_ready=1. err_clr pulse -> err=0. Next block decrypts normally.
4. Core holds dec_valid high continuously from the previous block -> no capture until dec_valid falls and re-rises; a timeout occurs if it never re-rises.
5. out_ready toggled 1-0-0-1 randomly during DRAIN -> out_word stable while stalled; exactly 4 transfers; in_ready stays 0 until the drain completes.
6. rst=0 asserted in BUSY, then a new block sent -> all outputs return to reset values; the old capture is never emitted; the new block decrypts correctly with blocks_done=1.

Source files
------------

// File: rtl/aes_decrypt_feeder_if.sv
// aes_decrypt_feeder_if: word bus, decrypt-core handshake and status signals of the AES decrypt feeder
interface aes_decrypt_feeder_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      in_word;
    logic             in_valid;
    logic             in_ready;
    logic             key_valid;
    logic [127:0]     dec_data_in;
    logic             dec_ready;
    logic [127:0]     dec_data_out;
    logic             dec_valid;
    logic [31:0]      out_word;
    logic             out_valid;
    logic             out_ready;
    logic             err;
    logic             err_clr;
    logic [CNT_W-1:0] blocks_done;
    modport master (
        output in_word, in_valid, key_valid, dec_data_out, dec_valid, out_ready, err_clr,
        input  in_ready, dec_data_in, dec_ready, out_word, out_valid, err, blocks_done
    );
    modport slave (
        input  in_word, in_valid, key_valid, dec_data_out, dec_valid, out_ready, err_clr,
        output in_ready, dec_data_in, dec_ready, out_word, out_valid, err, blocks_done
    );
endinterface

// File: rtl/aes_decrypt_feeder.sv
// aes_decrypt_feeder: packs 4 ciphertext words into a block, starts the AES-256 decrypt core,
// captures the plaintext on a dec_valid rising edge and streams it back as 4 words.
module aes_decrypt_feeder #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input logic                 clk,
    input logic                 rst,
    aes_decrypt_feeder_if.slave bus
);
    localparam logic [2:0] S_FILL  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_BUSY  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    logic [2:0]       r_state;
    logic [1:0]       r_idx;
    logic [127:0]     r_din;
    logic [127:0]     r_buf;
    logic [9:0]       r_cnt;
    logic             r_dvq;
    logic             r_err;
    logic [CNT_W-1:0] r_done;
    logic [1:0]       w_sel;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_capture;
    logic             w_timeout;
    // word 0 is the most significant word of the block
    assign w_sel      = ~r_idx;
    assign w_in_fire  = bus.in_valid & bus.in_ready;
    assign w_out_fire = bus.out_valid & bus.out_ready;
    assign w_capture  = (r_state == S_BUSY) & bus.dec_valid & ~r_dvq;
    assign w_timeout  = (r_state == S_BUSY) & ~w_capture & (r_cnt == 10'(TIMEOUT_CYCLES - 1));
    assign bus.in_ready    = rst & (r_state == S_FILL);
    assign bus.dec_ready   = (r_state == S_START);
    assign bus.dec_data_in = r_din;
    assign bus.out_valid   = (r_state == S_DRAIN);
    assign bus.out_word    = r_buf[{w_sel, 5'd0} +: 32];
    assign bus.err         = r_err;
    assign bus.blocks_done = r_done;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FILL;
            r_idx   <= 2'd0;
            r_din   <= '0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_dvq   <= 1'b1;
            r_err   <= 1'b0;
            r_done  <= '0;
        end else begin
            r_dvq <= bus.dec_valid;
            r_err <= w_timeout ? 1'b1 : (bus.err_clr ? 1'b0 : r_err);
            case (r_state)
                S_FILL: if (w_in_fire) begin
                    r_din[{w_sel, 5'd0} +: 32] <= bus.in_word;
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) r_state <= S_WAIT;
                end
                S_WAIT: if (bus.key_valid) r_state <= S_START;
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_BUSY;
                end
                // only a fresh rising edge of dec_valid belongs to this block
                S_BUSY: if (w_capture) begin
                    r_buf   <= bus.dec_data_out;
                    r_done  <= r_done + CNT_W'(1);
                    r_state <= S_DRAIN;
                end else if (w_timeout) begin
                    r_state <= S_FILL;
                end else begin
                    r_cnt <= r_cnt + 10'd1;
                end
                S_DRAIN: if (w_out_fire) begin
                    r_idx <= r_idx + 2'd1;
                    if (r_idx == 2'd3) r_state <= S_FILL;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_decrypt_feeder.sv
// tb_aes_decrypt_feeder: randomized self-checking bench with a behavioural decrypt-core model
module tb_aes_decrypt_feeder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    aes_decrypt_feeder_if #(.CNT_W(16)) ifc();
    aes_decrypt_feeder #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;
    int n_total = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int ready_cnt = 0;
    int exp_done = 0;
    // core model: 0 pulse result, 1 never answer, 2 answer and hold high, 4 ignore starts
    int core_mode = 0;
    int core_lat = 16;
    bit use_fixed = 1'b0;
    logic [127:0] fixed_resp = 128'h1212121234343434ababababcdcdcdcd;
    function automatic logic [127:0] plain(input logic [127:0] b);
        return {b[63:0], b[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction
    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction
    initial forever begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (ifc.dec_ready === 1'b1) ready_cnt++;
    end
    initial begin
        int cnt = 0;
        int hold = 0;
        bit pend = 1'b0;
        logic [127:0] blk = '0;
        ifc.dec_valid = 1'b0;
        ifc.dec_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.dec_ready && core_mode != 4) begin
                pend = 1'b1;
                cnt = core_lat;
                blk = ifc.dec_data_in;
                ifc.dec_valid = 1'b0;
                hold = 0;
            end else if (pend) begin
                if (cnt > 1) cnt--;
                else begin
                    pend = 1'b0;
                    if (core_mode != 1) begin
                        ifc.dec_valid = 1'b1;
                        ifc.dec_data_out = use_fixed ? fixed_resp : plain(blk);
                        hold = 3;
                    end
                end
            end else if (hold > 0 && core_mode != 2) begin
                hold--;
                if (hold == 0) ifc.dec_valid = 1'b0;
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send_block(input logic [127:0] blk);
        int t;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                ifc.in_valid = 1'b0;
                step();
            end
            ifc.in_word = blk[(3-k)*32 +: 32];
            ifc.in_valid = 1'b1;
            t = 0;
            while (!ifc.in_ready && t < 200) begin step(); t++; end
            if (ifc.in_ready !== 1'b1) begin
                n_total++;
                $display("FAIL in_ready_wait: got %b want 1", ifc.in_ready);
                ifc.in_valid = 1'b0;
                return;
            end
            acc_cyc = cyc;
            step();
        end
        ifc.in_valid = 1'b0;
    endtask
    task automatic wait_dec_ready(output int s);
        int t = 0;
        while (!ifc.dec_ready && t < 100) begin step(); t++; end
        s = cyc;
        n_total++;
        if (ifc.dec_ready !== 1'b1) $display("FAIL dec_ready_wait: got %b want 1", ifc.dec_ready);
        else n_pass++;
    endtask
    task automatic recv_block(input logic [127:0] exp, input bit stall);
        int t = 0;
        int k = 0;
        logic [31:0] w;
        while (!ifc.out_valid && t < 200) begin step(); t++; end
        n_total++;
        if (ifc.out_valid !== 1'b1) begin
            $display("FAIL out_valid_wait: got %b want 1", ifc.out_valid);
            return;
        end
        n_pass++;
        t = 0;
        while (k < 4 && t < 400) begin
            w = exp[(3-k)*32 +: 32];
            ifc.out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            n_total++;
            if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0 || ifc.out_word !== w)
                $display("FAIL drain_word%0d: got valid=%b in_ready=%b word=%h want valid=1 in_ready=0 word=%h",
                         k, ifc.out_valid, ifc.in_ready, ifc.out_word, w);
            else n_pass++;
            if (ifc.out_ready) k++;
            step();
            t++;
        end
        ifc.out_ready = 1'b0;
        n_total++;
        if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1)
            $display("FAIL drain_end: got valid=%b in_ready=%b want valid=0 in_ready=1", ifc.out_valid, ifc.in_ready);
        else n_pass++;
    endtask
    task automatic check_done();
        n_total++;
        if (ifc.blocks_done !== 16'(exp_done)) $display("FAIL blocks_done: got %0d want %0d", ifc.blocks_done, exp_done);
        else n_pass++;
    endtask
    task automatic pulse_err_clr();
        ifc.err_clr = 1'b1;
        step();
        ifc.err_clr = 1'b0;
        n_total++;
        if (ifc.err !== 1'b0) $display("FAIL err_clr: got %b want 0", ifc.err);
        else n_pass++;
    endtask
    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_total++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.dec_ready !== 1'b0 || ifc.err !== 1'b0)
            $display("FAIL reset_ctrl: got in_ready=%b out_valid=%b dec_ready=%b err=%b want all 0",
                     ifc.in_ready, ifc.out_valid, ifc.dec_ready, ifc.err);
        else n_pass++;
        n_total++;
        if (ifc.blocks_done !== 16'd0 || ifc.dec_data_in !== 128'd0 || ifc.out_word !== 32'd0)
            $display("FAIL reset_data: got done=%0d din=%h word=%h want 0", ifc.blocks_done, ifc.dec_data_in, ifc.out_word);
        else n_pass++;
        rst = 1'b1;
        step();
        n_total++;
        if (ifc.in_ready !== 1'b1) $display("FAIL reset_release: got in_ready=%b want 1", ifc.in_ready);
        else n_pass++;
    endtask
    task automatic test_basic();
        logic [127:0] blk = 128'ha52422117500d3e82c96d0dafc491931;
        int s;
        int r0;
        use_fixed = 1'b1;
        core_mode = 0;
        core_lat = 16;
        ifc.key_valid = 1'b1;
        r0 = ready_cnt;
        send_block(blk);
        n_total++;
        if (ifc.dec_data_in !== blk) $display("FAIL basic_din: got %h want %h", ifc.dec_data_in, blk);
        else n_pass++;
        wait_dec_ready(s);
        n_total++;
        if (s !== acc_cyc + 2) $display("FAIL basic_latency: got %0d want %0d", s - acc_cyc, 2);
        else n_pass++;
        repeat (8) step();
        n_total++;
        if (ifc.dec_data_in !== blk) $display("FAIL basic_din_busy: got %h want %h", ifc.dec_data_in, blk);
        else n_pass++;
        recv_block(fixed_resp, 1'b0);
        exp_done++;
        check_done();
        n_total++;
        if (ready_cnt - r0 !== 1 || ifc.err !== 1'b0)
            $display("FAIL basic_pulses: got pulses=%0d err=%b want pulses=1 err=0", ready_cnt - r0, ifc.err);
        else n_pass++;
    endtask
    task automatic test_key_wait();
        logic [127:0] blk = rnd_blk();
        int r0;
        use_fixed = 1'b1;
        ifc.key_valid = 1'b0;
        r0 = ready_cnt;
        send_block(blk);
        repeat (30) step();
        n_total++;
        if (ready_cnt !== r0 || ifc.dec_ready !== 1'b0)
            $display("FAIL key_hold: got pulses=%0d want 0", ready_cnt - r0);
        else n_pass++;
        ifc.key_valid = 1'b1;
        step();
        n_total++;
        if (ifc.dec_ready !== 1'b1) $display("FAIL key_start: got dec_ready=%b want 1", ifc.dec_ready);
        else n_pass++;
        recv_block(fixed_resp, 1'b0);
        exp_done++;
        check_done();
    endtask
    task automatic test_timeout();
        logic [127:0] blk = rnd_blk();
        int s;
        bit saw_out = 1'b0;
        use_fixed = 1'b0;
        core_mode = 1;
        send_block(blk);
        wait_dec_ready(s);
        ifc.err_clr = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            step();
            if (ifc.out_valid) saw_out = 1'b1;
        end
        n_total++;
        if (ifc.err !== 1'b0 || saw_out) $display("FAIL timeout_early: got err=%b out_valid_seen=%b want 0 0", ifc.err, saw_out);
        else n_pass++;
        step();
        ifc.err_clr = 1'b0;
        n_total++;
        if (ifc.err !== 1'b1 || ifc.in_ready !== 1'b1)
            $display("FAIL timeout_set: got err=%b in_ready=%b want 1 1", ifc.err, ifc.in_ready);
        else n_pass++;
        check_done();
        pulse_err_clr();
        core_mode = 0;
        blk = rnd_blk();
        send_block(blk);
        recv_block(plain(blk), 1'b0);
        exp_done++;
        check_done();
    endtask
    task automatic test_hold_high();
        logic [127:0] blk = rnd_blk();
        int t = 0;
        bit saw_out = 1'b0;
        use_fixed = 1'b0;
        core_mode = 2;
        core_lat = $urandom_range(3, 30);
        send_block(blk);
        recv_block(plain(blk), 1'b0);
        exp_done++;
        check_done();
        core_mode = 4;
        send_block(rnd_blk());
        while (!ifc.err && t < 150) begin
            step();
            if (ifc.out_valid) saw_out = 1'b1;
            t++;
        end
        n_total++;
        if (ifc.err !== 1'b1 || saw_out) $display("FAIL hold_ignored: got err=%b out_valid_seen=%b want 1 0", ifc.err, saw_out);
        else n_pass++;
        check_done();
        pulse_err_clr();
        core_mode = 2;
        blk = rnd_blk();
        send_block(blk);
        recv_block(plain(blk), 1'b0);
        exp_done++;
        check_done();
        core_mode = 0;
    endtask
    task automatic test_back_to_back();
        logic [127:0] blk;
        use_fixed = 1'b0;
        core_mode = 0;
        for (int i = 0; i < 4; i++) begin
            blk = rnd_blk();
            core_lat = $urandom_range(2, 40);
            send_block(blk);
            recv_block(plain(blk), 1'b1);
            exp_done++;
            check_done();
        end
    endtask
    task automatic test_reset_busy();
        logic [127:0] blk = rnd_blk();
        int s;
        bit saw_out = 1'b0;
        core_mode = 0;
        core_lat = 16;
        send_block(blk);
        wait_dec_ready(s);
        repeat (3) step();
        rst = 1'b0;
        step();
        n_total++;
        if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.dec_ready !== 1'b0 || ifc.err !== 1'b0 ||
            ifc.blocks_done !== 16'd0 || ifc.dec_data_in !== 128'd0)
            $display("FAIL busy_reset: got in_ready=%b out_valid=%b dec_ready=%b err=%b done=%0d din=%h want all 0",
                     ifc.in_ready, ifc.out_valid, ifc.dec_ready, ifc.err, ifc.blocks_done, ifc.dec_data_in);
        else n_pass++;
        rst = 1'b1;
        exp_done = 0;
        repeat (30) begin
            step();
            if (ifc.out_valid) saw_out = 1'b1;
        end
        n_total++;
        if (saw_out) $display("FAIL stale_capture: got out_valid=1 want 0");
        else n_pass++;
        blk = rnd_blk();
        send_block(blk);
        recv_block(plain(blk), 1'b1);
        exp_done++;
        check_done();
    endtask
    initial begin
        ifc.in_word = '0;
        ifc.in_valid = 1'b0;
        ifc.key_valid = 1'b0;
        ifc.out_ready = 1'b0;
        ifc.err_clr = 1'b0;
        test_reset();
        test_basic();
        test_key_wait();
        test_timeout();
        test_hold_high();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
